// File: rtl/cu_sequencer.sv
// cu_sequencer: top-level control sequencer for the multicycle ARM-subset CPU.
//
// Owns the 4-bit state register and the registered {V,C,N,Z} status flags.
// FETCH issues a fixed control word. EX0..EX3 forward the control word,
// k_mux select and next state of one of four sub-decoders. The sub-decoder is
// chosen from IR[28:25]. Illegal next states, undefined instructions and a
// runaway-execute watchdog all send the core to a sticky HALT state.
//
// Optional build macro: CU_PERF_CNT_EN adds the perf_cycles and perf_retired
// counters. When it is undefined, those ports do not exist.
//
// Stall semantics: mem_stall=1 means memory is not ready this cycle. In FETCH
// and EX*, the state register and the watchdog hold. The emitted control word
// has every side-effecting field cleared (w_reg, mem_write_en, IR_load,
// status_load, PC_FS). No transfer is assumed to complete until a cycle with
// mem_stall=0. HALT ignores mem_stall.
module cu_sequencer #(
  parameter int             CUL           = 36,
  parameter logic [CUL:0]   FETCH_CW      = 37'h0_0000_0261,
  parameter int             MAX_EX_CYCLES = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [31:0]    IR,
  input  logic [3:0]     status_in,
  input  logic           mem_stall,
  input  logic [CUL:0]   cw_br,
  input  logic [CUL:0]   cw_di,
  input  logic [CUL:0]   cw_dr,
  input  logic [CUL:0]   cw_mem,
  input  logic [3:0]     ns_br,
  input  logic [3:0]     ns_di,
  input  logic [3:0]     ns_dr,
  input  logic [3:0]     ns_mem,
  input  logic [2:0]     k_br,
  input  logic [2:0]     k_di,
  input  logic [2:0]     k_dr,
  input  logic [2:0]     k_mem,
  output logic [3:0]     state,
  output logic [3:0]     status,
  output logic [CUL:0]   controlWord,
  output logic [2:0]     k_mux,
  output logic           halted
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_retired
`endif
);

  localparam int CW_W = CUL + 1;
  localparam int WD_W = $clog2(MAX_EX_CYCLES + 1);

  // Control word bit positions that a stall must suppress.
  localparam int BIT_PC_FS0       = 0;
  localparam int BIT_PC_FS1       = 1;
  localparam int BIT_STATUS_LOAD  = 8;
  localparam int BIT_IR_LOAD      = 9;
  localparam int BIT_MEM_WRITE_EN = 10;
  localparam int BIT_W_REG        = 15;

  localparam logic [CUL:0] STALL_MASK =
      (CW_W'(1) << BIT_PC_FS0)      | (CW_W'(1) << BIT_PC_FS1)  |
      (CW_W'(1) << BIT_STATUS_LOAD) | (CW_W'(1) << BIT_IR_LOAD) |
      (CW_W'(1) << BIT_MEM_WRITE_EN)| (CW_W'(1) << BIT_W_REG);

  typedef enum logic [3:0] {
    S_FETCH = 4'h0,
    S_EX0   = 4'h1,
    S_EX1   = 4'h2,
    S_EX2   = 4'h3,
    S_EX3   = 4'h4,
    S_HALT  = 4'hF
  } state_t;

  typedef enum logic [2:0] {
    CLS_DI,
    CLS_BR,
    CLS_MEM,
    CLS_DR,
    CLS_UNDEF
  } cls_t;

  state_t            state_q, state_d;
  logic [3:0]        status_q;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  cls_t              cls;
  logic [3:0]        op_bits;
  logic [CUL:0]      cw_sel;
  logic [CUL:0]      cw_raw;
  logic [2:0]        k_sel;
  logic [3:0]        ns_sel;
  logic              in_fetch;
  logic              in_ex;

  // Only IR[28:25] selects the class; the rest of IR belongs to the sub-decoders.
  logic unused_ir;
  assign unused_ir = ^{IR[31:29], IR[24:0]};

  assign op_bits = IR[28:25];
  assign state   = state_q;
  assign status  = status_q;

  // Instruction class from IR[28:25]. The earlier tests take priority.
  always_comb begin
    cls = CLS_UNDEF;
    if (op_bits[3:1] == 3'b100) begin
      cls = CLS_DI;
    end else if (op_bits[3:1] == 3'b101) begin
      cls = CLS_BR;
    end else if (op_bits[2] && !op_bits[0]) begin
      cls = CLS_MEM;
    end else if (op_bits[2:0] == 3'b101) begin
      cls = CLS_DR;
    end
  end

  // Select the sub-decoder that owns the current instruction.
  // An undefined class yields a zero word and an illegal next state.
  always_comb begin
    cw_sel = '0;
    k_sel  = '0;
    ns_sel = S_HALT;
    case (cls)
      CLS_DI:  begin cw_sel = cw_di;  k_sel = k_di;  ns_sel = ns_di;  end
      CLS_BR:  begin cw_sel = cw_br;  k_sel = k_br;  ns_sel = ns_br;  end
      CLS_MEM: begin cw_sel = cw_mem; k_sel = k_mem; ns_sel = ns_mem; end
      CLS_DR:  begin cw_sel = cw_dr;  k_sel = k_dr;  ns_sel = ns_dr;  end
      default: begin cw_sel = '0;     k_sel = '0;    ns_sel = S_HALT; end
    endcase
  end

  // Datapath outputs for the current state. A stall gates off the side effects.
  always_comb begin
    cw_raw   = '0;
    k_mux    = '0;
    in_fetch = 1'b0;
    in_ex    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        in_fetch = 1'b1;
        cw_raw   = FETCH_CW;
      end
      S_EX0, S_EX1, S_EX2, S_EX3: begin
        in_ex  = 1'b1;
        cw_raw = cw_sel;
        k_mux  = k_sel;
      end
      default: begin
        // HALT and any illegal encoding behave identically.
        halted = 1'b1;
      end
    endcase
    controlWord = cw_raw;
    if (mem_stall && (in_fetch || in_ex)) begin
      controlWord = cw_raw & ~STALL_MASK;
    end
  end

  // Next-state and watchdog decision.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    wd_inc  = wd_q + WD_W'(1);
    case (state_q)
      S_FETCH: begin
        wd_d = '0;
        if (!mem_stall) begin
          state_d = S_EX0;
        end
      end
      S_EX0, S_EX1, S_EX2, S_EX3: begin
        if (!mem_stall) begin
          if (cls == CLS_UNDEF) begin
            state_d = S_HALT;
          end else begin
            case (ns_sel)
              4'h0:    state_d = S_FETCH;
              4'h2:    state_d = S_EX1;
              4'h3:    state_d = S_EX2;
              4'h4:    state_d = S_EX3;
              default: state_d = S_HALT;
            endcase
          end
          if (state_d == S_FETCH) begin
            wd_d = '0;
          end else begin
            wd_d = wd_inc;
            // This cycle is the last one the instruction may spend in EX.
            if (wd_inc >= WD_W'(MAX_EX_CYCLES)) begin
              state_d = S_HALT;
            end
          end
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State register and watchdog counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Status flags load only when the emitted (post-gating) word asks for it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q <= '0;
    end else if (controlWord[BIT_STATUS_LOAD]) begin
      status_q <= status_in;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic retire;
  assign retire = in_ex && (state_d == S_FETCH);

  // Free-running perf counters. They wrap naturally and freeze once halted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else if (!halted) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (retire) begin
        perf_retired <= perf_retired + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Testbench for cu_sequencer.
// Each step drives inputs after a rising edge and pushes the expected outputs
// for that cycle. The observed outputs are popped and compared on the falling edge.
module tb_cu_sequencer;

  localparam int           CUL       = 36;
  localparam int           EXP_W     = 4 + 4 + 1 + 3 + CUL + 1;
  localparam logic [CUL:0] FETCH_CW  = 37'h0_0000_0261;
  localparam logic [CUL:0] GATE_MASK = 37'h0_0000_8703;
  localparam logic [31:0]  IR_DI     = 32'h9100_0421;
  localparam logic [31:0]  IR_MEM    = 32'hF840_0020;
  localparam logic [31:0]  IR_BR     = 32'h1400_0004;
  localparam logic [31:0]  IR_DR     = 32'h0A00_0000;
  localparam logic [31:0]  IR_UNDEF  = 32'h0000_0000;
  localparam logic [2:0]   K_BR = 3'd1, K_DI = 3'd2, K_DR = 3'd3, K_MEM = 3'd4;

  logic           clock, reset;
  logic [31:0]    IR;
  logic [3:0]     status_in;
  logic           mem_stall;
  logic [CUL:0]   cw_br, cw_di, cw_dr, cw_mem;
  logic [3:0]     ns_br, ns_di, ns_dr, ns_mem;
  logic [2:0]     k_br, k_di, k_dr, k_mem;
  logic [3:0]     state, status;
  logic [CUL:0]   controlWord;
  logic [2:0]     k_mux;
  logic           halted;
`ifdef CU_PERF_CNT_EN
  logic [31:0]    perf_cycles, perf_retired;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  cu_sequencer dut (
    .clock(clock), .reset(reset), .IR(IR), .status_in(status_in),
    .mem_stall(mem_stall),
    .cw_br(cw_br), .cw_di(cw_di), .cw_dr(cw_dr), .cw_mem(cw_mem),
    .ns_br(ns_br), .ns_di(ns_di), .ns_dr(ns_dr), .ns_mem(ns_mem),
    .k_br(k_br), .k_di(k_di), .k_dr(k_dr), .k_mem(k_mem),
    .state(state), .status(status), .controlWord(controlWord),
    .k_mux(k_mux), .halted(halted)
`ifdef CU_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CUL:0] rand_cw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CUL:0];
  endfunction

  // Scoreboard push: expected outputs for the cycle being driven.
  task automatic sb_push(input logic [3:0] st, input logic [3:0] stat, input logic hl,
                         input logic [2:0] k, input logic [CUL:0] cw);
    exp_q.push_back({st, stat, hl, k, cw});
  endtask

  // Scoreboard pop: compare the DUT outputs against the oldest expectation.
  task automatic sb_compare(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, ".state"},  64'(state),       64'(e[EXP_W-1 -: 4]));
    check_eq({tag, ".status"}, 64'(status),      64'(e[EXP_W-5 -: 4]));
    check_eq({tag, ".halted"}, 64'(halted),      64'(e[CUL+4]));
    check_eq({tag, ".k_mux"},  64'(k_mux),       64'(e[CUL+3 -: 3]));
    check_eq({tag, ".cw"},     64'(controlWord), 64'(e[CUL:0]));
  endtask

  // Driver: the inputs are already applied; check this cycle, then let the edge act.
  task automatic step(input string tag, input logic [3:0] st, input logic [3:0] stat,
                      input logic hl, input logic [2:0] k, input logic [CUL:0] cw);
    sb_push(st, stat, hl, k, cw);
    @(negedge clock);
    sb_compare(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    mem_stall = 1'b0;
    #1;
    sb_push(4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    sb_compare(tag);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IR = IR_UNDEF; status_in = 4'h0; mem_stall = 1'b0;
    cw_br = rand_cw(); cw_di = rand_cw(); cw_dr = rand_cw(); cw_mem = rand_cw();
    ns_br = 4'h0; ns_di = 4'h0; ns_dr = 4'h0; ns_mem = 4'h0;
    k_br = K_BR; k_di = K_DI; k_dr = K_DR; k_mem = K_MEM;
    @(posedge clock);
    #1;
    do_reset("reset");

`ifdef CU_PERF_CNT_EN
    // Three single-EX instructions: six cycles, three retirements.
    IR = IR_DI; ns_di = 4'h0; cw_di = rand_cw(); cw_di[8] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("perf_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
      step("perf_ex0", 4'h1, 4'h0, 1'b0, K_DI, cw_di);
    end
    check_eq("perf_retired", 64'(perf_retired), 64'd3);
    check_eq("perf_cycles", 64'(perf_cycles), 64'd6);
    do_reset("perf_reset");
`endif

    // Data-immediate, single EX cycle.
    IR = IR_DI; ns_di = 4'h0; cw_di = rand_cw(); cw_di[8] = 1'b0;
    step("di_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    step("di_ex0", 4'h1, 4'h0, 1'b0, K_DI, cw_di);

    // A stall in FETCH holds the state and gates IR_load and PC_FS.
    mem_stall = 1'b1;
    step("fetch_stall", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW & ~GATE_MASK);
    mem_stall = 1'b0;

    // Memory instruction with a 3-cycle stall in EX1.
    IR = IR_MEM; ns_mem = 4'h2; cw_mem = rand_cw() | GATE_MASK; status_in = 4'h0;
    step("mem_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    step("mem_ex0", 4'h1, 4'h0, 1'b0, K_MEM, cw_mem);
    ns_mem = 4'h0; mem_stall = 1'b1; status_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step("mem_stall", 4'h2, 4'h0, 1'b0, K_MEM, cw_mem & ~GATE_MASK);
    end
    mem_stall = 1'b0; status_in = 4'h0;
    step("mem_ex1", 4'h2, 4'h0, 1'b0, K_MEM, cw_mem);

    // The branch loads status; FETCH and a DR instruction without bit 8 do not.
    IR = IR_BR; ns_br = 4'h0; cw_br = rand_cw(); cw_br[8] = 1'b1; status_in = 4'b1010;
    step("br_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    status_in = 4'b0101;
    step("br_ex0", 4'h1, 4'h0, 1'b0, K_BR, cw_br);
    IR = IR_DR; ns_dr = 4'h0; cw_dr = rand_cw(); cw_dr[8] = 1'b0; status_in = 4'b1111;
    step("dr_fetch", 4'h0, 4'b0101, 1'b0, 3'd0, FETCH_CW);
    step("dr_ex0", 4'h1, 4'b0101, 1'b0, K_DR, cw_dr);
    step("dr_after", 4'h0, 4'b0101, 1'b0, 3'd0, FETCH_CW);
    status_in = 4'h0;
    do_reset("reset_status");

    // Walk through EX0 -> EX2 -> EX3 -> FETCH.
    IR = IR_DI; cw_di = rand_cw(); cw_di[8] = 1'b0;
    step("walk_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    ns_di = 4'h3;
    step("walk_ex0", 4'h1, 4'h0, 1'b0, K_DI, cw_di);
    ns_di = 4'h4;
    step("walk_ex2", 4'h3, 4'h0, 1'b0, K_DI, cw_di);
    ns_di = 4'h0;
    step("walk_ex3", 4'h4, 4'h0, 1'b0, K_DI, cw_di);
    step("walk_done", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    do_reset("reset_walk");

    // Watchdog: ns stuck at EX1 halts after 8 EX cycles.
    IR = IR_DR; ns_dr = 4'h2; cw_dr = rand_cw(); cw_dr[8] = 1'b0;
    step("wd_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    step("wd_ex0", 4'h1, 4'h0, 1'b0, K_DR, cw_dr);
    for (int i = 0; i < 7; i++) begin
      step("wd_ex1", 4'h2, 4'h0, 1'b0, K_DR, cw_dr);
    end
    step("wd_halt", 4'hF, 4'h0, 1'b1, 3'd0, '0);
    do_reset("reset_wd");

    // An illegal next state from a sub-decoder halts on the next edge.
    IR = IR_DR; ns_dr = 4'h7;
    step("ill_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    step("ill_ex0", 4'h1, 4'h0, 1'b0, K_DR, cw_dr);
    step("ill_halt", 4'hF, 4'h0, 1'b1, 3'd0, '0);
    do_reset("reset_ill");

    // An undefined instruction halts, and HALT ignores stall toggling.
    IR = IR_UNDEF;
    step("undef_fetch", 4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    step("undef_ex0", 4'h1, 4'h0, 1'b0, 3'd0, '0);
    for (int i = 0; i < 4; i++) begin
      mem_stall = i[0];
      step("halt_hold", 4'hF, 4'h0, 1'b1, 3'd0, '0);
    end
    mem_stall = 1'b0;

    // An asynchronous reset mid-HALT takes effect without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    sb_push(4'h0, 4'h0, 1'b0, 3'd0, FETCH_CW);
    sb_compare("async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
